// File: rtl/chiplet_types_pkg.sv
// Shared types for the endpoint message path: TX scheduler state encoding and
// a message-id width helper.
package chiplet_types_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } tx_sched_state_e;

  localparam int DEFAULT_NUM_MSGS = 4;

  // Width of an index into n slots; never narrower than one bit.
  function automatic int msg_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [msg_id_w(DEFAULT_NUM_MSGS)-1:0] msg_id_t;

endpackage

// File: rtl/tx_msg_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request bit after last_i,
// wrapping modulo NUM_MSGS (power of two, so wrap is plain truncation).
module rr_pick
  import chiplet_types_pkg::*;
#(
  parameter int NUM_MSGS = 4
) (
  input  logic [NUM_MSGS-1:0]           req_i,
  input  logic [msg_id_w(NUM_MSGS)-1:0] last_i,
  output logic                          valid_o,
  output logic [msg_id_w(NUM_MSGS)-1:0] idx_o
);

  localparam int ID_W = msg_id_w(NUM_MSGS);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    valid_o = |req_i;
    idx_o   = last_i;
    cand    = last_i;
    found   = 1'b0;
    for (int i = 1; i <= NUM_MSGS; i++) begin
      cand = last_i + ID_W'(i);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_msg_scheduler.sv
// Round-robin send scheduler between the message table and the TX FSM.
// Optional watchdog abort of a stuck send is built when TX_SCHED_WATCHDOG_EN is defined.
module tx_msg_scheduler
  import chiplet_types_pkg::*;
#(
  parameter int NUM_MSGS  = 4,
  parameter int WD_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_MSGS-1:0]           trigger_send,
  output logic                          tx_req,
  output logic [msg_id_w(NUM_MSGS)-1:0] tx_msg_id,
  input  logic                          tx_ack,
  input  logic                          tx_done,
  output logic [NUM_MSGS-1:0]           pending,
  output logic                          in_flight,
  output logic                          dup_err,
  output logic                          wd_abort,
  output logic [15:0]                   done_count
);

  localparam int ID_W = msg_id_w(NUM_MSGS);

  if (NUM_MSGS < 2 || (NUM_MSGS & (NUM_MSGS - 1)) != 0 || WD_CYCLES < 2) begin : g_bad_cfg
    $error("tx_msg_scheduler: NUM_MSGS must be a power of two >= 2 and WD_CYCLES >= 2");
  end

  tx_sched_state_e     state_q, state_d;
  logic [ID_W-1:0]     tx_msg_id_q, tx_msg_id_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_MSGS-1:0] pending_q, pending_d;
  logic [NUM_MSGS-1:0] clear_mask, dup_mask;
  logic [15:0]         done_count_q, done_count_d;
  logic                tx_req_q, in_flight_q, dup_err_q;
  logic                pick_valid, active, wd_fire;
  logic [ID_W-1:0]     pick_idx;

  rr_pick #(.NUM_MSGS(NUM_MSGS)) u_rr_pick (
    .req_i   (pending_q),
    .last_i  (last_grant_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef TX_SCHED_WATCHDOG_EN
  localparam int              WD_W    = msg_id_w(WD_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_abort_q;

  // Completion in the expiry cycle wins over the abort.
  assign wd_fire = (state_q == WAIT_DONE) && !tx_done && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt_q   <= '0;
      wd_abort_q <= 1'b0;
    end else begin
      wd_cnt_q   <= (state_q == WAIT_DONE) ? wd_cnt_q + 1'b1 : '0;
      wd_abort_q <= wd_fire;
    end
  end

  assign wd_abort = wd_abort_q;
`else
  assign wd_fire  = 1'b0;
  assign wd_abort = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    tx_msg_id_d  = tx_msg_id_q;
    last_grant_d = last_grant_q;
    done_count_d = done_count_q;
    clear_mask   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          tx_msg_id_d          = pick_idx;
          last_grant_d         = pick_idx;
          clear_mask[pick_idx] = 1'b1;
          state_d              = REQ;
        end
      end
      REQ: begin
        if (tx_ack) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end else if (wd_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing slot is released before this cycle's triggers are screened.
    active = (state_q != IDLE) && !((state_q == WAIT_DONE) && tx_done);
    for (int i = 0; i < NUM_MSGS; i++) begin
      dup_mask[i] = pending_q[i] || (active && (tx_msg_id_q == ID_W'(i)));
    end
    pending_d = (pending_q & ~clear_mask) | (trigger_send & ~dup_mask);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      tx_msg_id_q  <= '0;
      last_grant_q <= ID_W'(NUM_MSGS - 1);
      pending_q    <= '0;
      done_count_q <= '0;
      tx_req_q     <= 1'b0;
      in_flight_q  <= 1'b0;
      dup_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      tx_msg_id_q  <= tx_msg_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      done_count_q <= done_count_d;
      tx_req_q     <= (state_d == REQ);
      in_flight_q  <= (state_d == WAIT_DONE);
      dup_err_q    <= |(trigger_send & dup_mask);
    end
  end

  assign tx_req     = tx_req_q;
  assign tx_msg_id  = tx_msg_id_q;
  assign pending    = pending_q;
  assign in_flight  = in_flight_q;
  assign dup_err    = dup_err_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_tx_msg_scheduler.sv
// Directed bench for tx_msg_scheduler (NUM_MSGS=4, WD_CYCLES=16); the watchdog
// section runs only when TX_SCHED_WATCHDOG_EN is defined.
module tb_tx_msg_scheduler;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  trigger_send;
  logic        tx_req;
  logic [1:0]  tx_msg_id;
  logic        tx_ack;
  logic        tx_done;
  logic [3:0]  pending;
  logic        in_flight;
  logic        dup_err;
  logic        wd_abort;
  logic [15:0] done_count;

  int n_checks = 0;
  int n_errors = 0;

  tx_msg_scheduler #(.NUM_MSGS(4), .WD_CYCLES(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .trigger_send (trigger_send),
    .tx_req       (tx_req),
    .tx_msg_id    (tx_msg_id),
    .tx_ack       (tx_ack),
    .tx_done      (tx_done),
    .pending      (pending),
    .in_flight    (in_flight),
    .dup_err      (dup_err),
    .wd_abort     (wd_abort),
    .done_count   (done_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int k = 0;
    while (tx_req !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(tx_req), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(tx_req),     32'd0);
    check({tag, "_id"},    32'(tx_msg_id),  32'd0);
    check({tag, "_pend"},  32'(pending),    32'd0);
    check({tag, "_infl"},  32'(in_flight),  32'd0);
    check({tag, "_dup"},   32'(dup_err),    32'd0);
    check({tag, "_wd"},    32'(wd_abort),   32'd0);
    check({tag, "_dcnt"},  32'(done_count), 32'd0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    step();
    step();
    n_rst = 1'b1;
    step();
  endtask

  initial begin
    n_rst        = 1'b0;
    trigger_send = '0;
    tx_ack       = 1'b0;
    tx_done      = 1'b0;

    // Reset values
    step();
    step();
    check_reset_outputs("rst");
    n_rst = 1'b1;
    step();

    // Single trigger on slot 2: pending at t+1, tx_req at t+2
    trigger_send = 4'b0100;
    step();
    trigger_send = '0;
    check("t1_pend",     32'(pending), 32'h4);
    check("t1_req_lat1", 32'(tx_req),  32'd0);
    step();
    check("t1_req", 32'(tx_req),    32'd1);
    check("t1_id",  32'(tx_msg_id), 32'd2);
    check("t1_pend_clr", 32'(pending), 32'h0);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    check("t1_req_drop", 32'(tx_req),    32'd0);
    check("t1_infl",     32'(in_flight), 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t1_infl_clr", 32'(in_flight),  32'd0);
    check("t1_dcnt",     32'(done_count), 32'd1);

    // All four slots at once after a fresh reset: grants rotate 0,1,2,3
    do_reset();
    trigger_send = 4'b1111;
    step();
    trigger_send = '0;
    check("rr_pend_all", 32'(pending), 32'hF);
    for (int g = 0; g < 4; g++) begin
      wait_req($sformatf("rr_req%0d", g), 8);
      check($sformatf("rr_id%0d", g),   32'(tx_msg_id), 32'(g));
      check($sformatf("rr_pend%0d", g), 32'(pending),   32'((4'b1111 << (g + 1)) & 4'hF));
      step();
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
      check($sformatf("rr_infl%0d", g), 32'(in_flight), 32'd1);
      step();
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check($sformatf("rr_infl_clr%0d", g), 32'(in_flight), 32'd0);
    end
    check("rr_dcnt", 32'(done_count), 32'd4);

    // Duplicate trigger while slot 1 is in WAIT_DONE, then retrigger with tx_done
    trigger_send = 4'b0010;
    step();
    trigger_send = '0;
    step();
    check("dup_id", 32'(tx_msg_id), 32'd1);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    check("dup_infl", 32'(in_flight), 32'd1);
    trigger_send = 4'b0010;
    step();
    trigger_send = '0;
    check("dup_err_pulse", 32'(dup_err), 32'd1);
    check("dup_pend",      32'(pending), 32'h0);
    step();
    check("dup_err_clr", 32'(dup_err), 32'd0);
    trigger_send = 4'b0010;
    tx_done      = 1'b1;
    step();
    trigger_send = '0;
    tx_done      = 1'b0;
    check("retrig_dup",  32'(dup_err),    32'd0);
    check("retrig_pend", 32'(pending),    32'h2);
    check("retrig_dcnt", 32'(done_count), 32'd5);
    step();
    check("retrig_req", 32'(tx_req),    32'd1);
    check("retrig_id",  32'(tx_msg_id), 32'd1);

    // Hold tx_ack low for 50 cycles; spurious tx_done and a dup trigger in REQ
    for (int c = 0; c < 50; c++) begin
      tx_done      = (c == 10);
      trigger_send = (c == 20) ? 4'b0010 : 4'b0000;
      step();
      check($sformatf("hold_req%0d", c), 32'(tx_req),    32'd1);
      check($sformatf("hold_id%0d", c),  32'(tx_msg_id), 32'd1);
      if (c == 20) check("hold_dup", 32'(dup_err), 32'd1);
    end
    tx_done      = 1'b0;
    trigger_send = '0;
    check("hold_dcnt", 32'(done_count), 32'd5);
    check("hold_infl", 32'(in_flight),  32'd0);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("hold_done_dcnt", 32'(done_count), 32'd6);

    // Asynchronous reset mid-WAIT_DONE with pending = 4'b1010
    trigger_send = 4'b0001;
    step();
    trigger_send = '0;
    step();
    check("ar_id", 32'(tx_msg_id), 32'd0);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    trigger_send = 4'b1010;
    step();
    trigger_send = '0;
    check("ar_pend",  32'(pending),   32'hA);
    check("ar_infl",  32'(in_flight), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("ar");
    step();
    n_rst = 1'b1;
    step();
    step();
    check("ar_idle_req",  32'(tx_req),  32'd0);
    check("ar_idle_pend", 32'(pending), 32'h0);
    trigger_send = 4'b0101;
    step();
    trigger_send = '0;
    step();
    check("ar_first_req", 32'(tx_req),    32'd1);
    check("ar_first_id",  32'(tx_msg_id), 32'd0);
    check("ar_wd_idle",   32'(wd_abort),  32'd0);

`ifdef TX_SCHED_WATCHDOG_EN
    // Watchdog: ack slot 0, never complete; abort 16 cycles after WAIT_DONE entry
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    for (int c = 1; c < 16; c++) begin
      step();
      check($sformatf("wd_quiet%0d", c), 32'(wd_abort), 32'd0);
    end
    step();
    check("wd_fire",      32'(wd_abort),   32'd1);
    check("wd_infl",      32'(in_flight),  32'd0);
    check("wd_dcnt",      32'(done_count), 32'd0);
    step();
    check("wd_pulse_end", 32'(wd_abort),   32'd0);
    check("wd_next_req",  32'(tx_req),     32'd1);
    check("wd_next_id",   32'(tx_msg_id),  32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_msg_scheduler.md
# tx_msg_scheduler

Round-robin scheduler that sits between the endpoint's bus-facing message table and the TX FSM. It latches one-cycle send triggers for each message slot, grants one slot at a time to the TX FSM through a req/ack/done handshake, and reports pending and in-flight status back to the bus side. An optional watchdog aborts a send that never completes.

## Interface
Parameters:
- NUM_MSGS, 4: number of message slots; must be a power of two, ≥2.
- WD_CYCLES, 1024: watchdog limit in cycles, counted in WAIT_DONE; used only with the watchdog compiled in.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- n_rst  in  1  asynchronous active-low reset.
- trigger_send  in  NUM_MSGS  one-cycle pulse per slot requesting a send; several bits may be high together.
- tx_req  out  1  grant request to the TX FSM; held high until tx_ack.
- tx_msg_id  out  $clog2(NUM_MSGS)  granted slot; stable while tx_req or in_flight is high.
- tx_ack  in  1  TX FSM accepted the grant.
- tx_done  in  1  one-cycle pulse when the TX FSM has finished the granted message.
- pending  out  NUM_MSGS  slots that are triggered but not yet granted.
- in_flight  out  1  a grant is acknowledged and its send is not yet complete.
- dup_err  out  1  one-cycle pulse: a trigger hit a slot that was already pending or granted.
- wd_abort  out  1  one-cycle pulse when the watchdog fires (tied 0 without the macro).
- done_count  out  16  completed sends; wraps modulo 2^16.

## Operation
- States are IDLE, REQ and WAIT_DONE.
- **IDLE**
  - If `pending` is nonzero, pick a winner round-robin: search starts at `last_grant+1` and wraps modulo NUM_MSGS.
  - Register the winner into `tx_msg_id` and `last_grant`, clear its pending bit, then go to REQ.
- **REQ**
  - `tx_req`=1.
  - On `tx_ack`, go to WAIT_DONE. `tx_req` drops the next cycle.
- **WAIT_DONE**
  - `in_flight`=1.
  - On `tx_done`: increment `done_count`, then go to IDLE.
- **Triggers**
  - For each bit i with `trigger_send[i]`=1:
    - if slot i is pending, or is the active grant (state REQ or WAIT_DONE with `tx_msg_id`=i), set `dup_err`=1 and drop the trigger;
    - otherwise set `pending[i]`.
  - Exception: a trigger for the active slot in the same cycle as `tx_done` is accepted with no error. Completion is applied first, then the trigger.
  - A trigger for the slot being selected in IDLE that same cycle is a duplicate.
- **Ordering**
  - A slot is never granted twice without an intervening completion or abort.
  - Fairness: with all slots pending, grants rotate 0,1,2,3,…
- **Protocol violations**
  - `tx_ack` outside REQ and `tx_done` outside WAIT_DONE are ignored.
- **Reset at any point**
  - State returns to IDLE.
  - `pending`=0; `last_grant`=NUM_MSGS-1, so the first grant goes to slot 0.
  - Any in-progress grant is abandoned; the TX FSM is reset by the same n_rst.

## Timing
- Reset values: `tx_req`=0, `tx_msg_id`=0, `pending`=0, `in_flight`=0, `dup_err`=0, `wd_abort`=0, `done_count`=0.
- Trigger in cycle t: `pending` bit visible at t+1, `tx_req` high at t+2 (state was IDLE).
- `tx_ack` at cycle a: `tx_req`=0 and `in_flight`=1 from a+1.
- `tx_done` at cycle d: `in_flight`=0 and `done_count` updated at d+1; next `tx_req` no earlier than d+2.
- `dup_err` is registered and appears one cycle after the offending trigger.
- All outputs are registered.

## Configuration
- `TX_SCHED_WATCHDOG_EN` defined:
  - A $clog2(WD_CYCLES)-bit counter clears on entry to WAIT_DONE and increments each cycle in it.
  - When it reaches WD_CYCLES-1 with no `tx_done`: pulse `wd_abort` the next cycle, go to IDLE, and leave `done_count` unchanged. The aborted slot is not re-queued.
  - `tx_done` in the same cycle as expiry counts as completion; no abort.
- Undefined: no counter is built, `wd_abort` is tied to 0, and WAIT_DONE waits indefinitely.

## Structure
- `chiplet_types_pkg` gains the `tx_sched_state_e` enum (IDLE, REQ, WAIT_DONE) and a `msg_id_t` width helper.
- One sub-module, `rr_pick`: a combinational round-robin picker.
  - Inputs: request mask, last grant.
  - Outputs: `valid`, winner index.
  - Parameterised by NUM_MSGS.

## Test plan
- Reset, then `trigger_send`=4'b0100 → `pending`=4'b0100 next cycle; `tx_req`=1 with `tx_msg_id`=2 two cycles after the trigger; ack then done → `done_count`=1.
- `trigger_send`=4'b1111 in one cycle; ack each grant 1 cycle later and pulse done 3 cycles later → grant order 0,1,2,3 and `done_count`=4.
- Slot 1 in WAIT_DONE; trigger slot 1 → `dup_err` pulse and `pending` unchanged. Retrigger slot 1 in the same cycle as `tx_done` → no error, `pending[1]`=1, and slot 1 is granted again.
- Leave `tx_ack` low for 50 cycles → `tx_req` stays high and `tx_msg_id` stays stable; spurious `tx_done` during REQ is ignored.
- Watchdog build with WD_CYCLES=16: ack, never send done → `wd_abort` pulses 16 cycles after WAIT_DONE entry, then the next pending slot is granted.
- Assert n_rst mid-WAIT_DONE with `pending`=4'b1010 → all outputs take reset values immediately, and after release the first grant goes to slot 0 only after a new trigger.
